tcpc_transmit_arbiter: RTL and testbench

Owns the PHY transmit path of the TCPC and schedules every transmission written to the TRANSMIT register: SOP* messages with retries, Hard Reset and Cable Reset.
Hard/Cable Reset pre-empts an in-flight message: it aborts the message and then runs reset signalling with a completion timer.
Reports each outcome to the ALERT logic as one-cycle pulses. Sits between the register block and the PHY.

---
 rtl/tcpc_transmit_arbiter_pkg.sv | 32 +++
 rtl/tcpc_transmit_arbiter_if.sv | 28 ++
 rtl/tcpc_down_timer.sv | 30 +++
 rtl/tcpc_transmit_arbiter.sv | 163 ++++++++++++++++
 tb/tb_tcpc_transmit_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tcpc_transmit_arbiter_pkg.sv
// Shared definitions for the TCPC transmit arbiter: state encoding,
// TRANSMIT register field positions and SOP* / reset type codes.
package tcpc_pkg;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_SOP_WAIT = 6'b000010,
    ST_SOP_GAP  = 6'b000100,
    ST_ABORT    = 6'b001000,
    ST_HR_WAIT  = 6'b010000,
    ST_REPORT   = 6'b100000
  } state_e;

  localparam int TX_TYPE_LSB  = 0;
  localparam int TX_TYPE_MSB  = 2;
  localparam int TX_RETRY_LSB = 4;
  localparam int TX_RETRY_MSB = 5;

  localparam logic [2:0] TYPE_SOP             = 3'd0;
  localparam logic [2:0] TYPE_SOP_PRIME       = 3'd1;
  localparam logic [2:0] TYPE_SOP_DPRIME      = 3'd2;
  localparam logic [2:0] TYPE_SOP_DBG_PRIME   = 3'd3;
  localparam logic [2:0] TYPE_SOP_DBG_DPRIME  = 3'd4;
  localparam logic [2:0] TYPE_HARD_RESET      = 3'd5;
  localparam logic [2:0] TYPE_CABLE_RESET     = 3'd6;
  localparam logic [2:0] TYPE_RESERVED        = 3'd7;

  function automatic logic is_reset_type(input logic [2:0] t);
    return (t == TYPE_HARD_RESET) || (t == TYPE_CABLE_RESET);
  endfunction

endpackage

// File: rtl/tcpc_transmit_arbiter_if.sv
// Register-block / PHY facing signals of the transmit arbiter.
// The slave modport is the arbiter; master is the surrounding logic.
interface tcpc_transmit_arbiter_if;
  logic       transmit_req;
  logic [7:0] TRANSMIT;
  logic       rx_busy;
  logic       phy_done;
  logic       phy_fail;
  logic       phy_request;
  logic [2:0] phy_sop_type;
  logic       phy_abort;
  logic       ALERT_TransmitSuccessful;
  logic       ALERT_TransmitSOPMessageFailed;
  logic       ALERT_TransmitSOPMessageDiscarded;
  logic       busy;

  modport slave (
    input  transmit_req, TRANSMIT, rx_busy, phy_done, phy_fail,
    output phy_request, phy_sop_type, phy_abort, ALERT_TransmitSuccessful,
           ALERT_TransmitSOPMessageFailed, ALERT_TransmitSOPMessageDiscarded, busy
  );

  modport master (
    output transmit_req, TRANSMIT, rx_busy, phy_done, phy_fail,
    input  phy_request, phy_sop_type, phy_abort, ALERT_TransmitSuccessful,
           ALERT_TransmitSOPMessageFailed, ALERT_TransmitSOPMessageDiscarded, busy
  );
endinterface

// File: rtl/tcpc_down_timer.sv
// Loadable down-counter that saturates at zero; expired while the count is zero.
module tcpc_down_timer #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               enable,
  output logic               expired
);

  logic [TIMER_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)
      value_d = load_value;
    else if (enable && (value_q != '0))
      value_d = value_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign expired = (value_q == '0);

endmodule

// File: rtl/tcpc_transmit_arbiter.sv
// Schedules SOP* transmissions with retries and Hard/Cable Reset signalling,
// with reset pre-empting an in-flight message; outcomes are one-cycle alerts.
module tcpc_transmit_arbiter
  import tcpc_pkg::*;
#(
  parameter int unsigned TIMER_W         = 32,
  parameter int unsigned MAX_RESET_TIMER = 1000,
  parameter int unsigned MAX_TX_TIMER    = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  tcpc_transmit_arbiter_if.slave bus
);

  state_e       state_q, state_d;
  logic [2:0]   type_q, type_d;
  logic [1:0]   retry_q, retry_d;
  logic [2:0]   attempts_q, attempts_d;
  logic         phy_request_q, phy_request_d;
  logic         phy_abort_q, phy_abort_d;
  logic         succ_q, succ_d;
  logic         fail_q, fail_d;
  logic         disc_q, disc_d;
  logic         busy_q, busy_d;

  logic               tmr_load, tmr_enable, tmr_expired;
  logic [TIMER_W-1:0] tmr_value;
  logic [2:0]         req_type;
  logic               req_reset;
  logic [2:0]         attempts_next;

  assign req_type      = bus.TRANSMIT[TX_TYPE_MSB:TX_TYPE_LSB];
  assign req_reset     = bus.transmit_req && is_reset_type(req_type);
  assign attempts_next = attempts_q + 3'd1;
  assign tmr_enable    = (state_q == ST_SOP_WAIT) || (state_q == ST_HR_WAIT);

  tcpc_down_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .enable     (tmr_enable),
    .expired    (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    retry_d    = retry_q;
    attempts_d = attempts_q;
    succ_d     = 1'b0;
    fail_d     = 1'b0;
    disc_d     = 1'b0;
    phy_abort_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = TIMER_W'(MAX_TX_TIMER);

    // A message request that cannot be started is dropped with a Discarded pulse.
    if (bus.transmit_req && !is_reset_type(req_type) && (state_q != ST_IDLE))
      disc_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.transmit_req) begin
          if (is_reset_type(req_type)) begin
            type_d    = req_type;
            state_d   = ST_HR_WAIT;
            tmr_load  = 1'b1;
            tmr_value = TIMER_W'(MAX_RESET_TIMER);
          end else if (req_type == TYPE_RESERVED) begin
            state_d = ST_REPORT;
            fail_d  = 1'b1;
          end else if (bus.rx_busy) begin
            state_d = ST_REPORT;
            disc_d  = 1'b1;
          end else begin
            type_d     = req_type;
            retry_d    = bus.TRANSMIT[TX_RETRY_MSB:TX_RETRY_LSB];
            attempts_d = 3'd0;
            state_d    = ST_SOP_WAIT;
            tmr_load   = 1'b1;
          end
        end
      end
      ST_SOP_WAIT, ST_SOP_GAP: begin
        if (req_reset) begin
          type_d      = req_type;
          state_d     = ST_ABORT;
          phy_abort_d = 1'b1;
          disc_d      = 1'b1;
        end else if (state_q == ST_SOP_GAP) begin
          state_d  = ST_SOP_WAIT;
          tmr_load = 1'b1;
        end else if (bus.phy_done) begin
          state_d = ST_REPORT;
          succ_d  = 1'b1;
        end else if (bus.phy_fail || tmr_expired) begin
          attempts_d = attempts_next;
          if (attempts_next > {1'b0, retry_q}) begin
            state_d = ST_REPORT;
            fail_d  = 1'b1;
          end else begin
            state_d = ST_SOP_GAP;
          end
        end
      end
      ST_ABORT: begin
        state_d   = ST_HR_WAIT;
        tmr_load  = 1'b1;
        tmr_value = TIMER_W'(MAX_RESET_TIMER);
      end
      ST_HR_WAIT: begin
        if (bus.phy_done) begin
          state_d = ST_REPORT;
          succ_d  = 1'b1;
        end else if (tmr_expired) begin
          state_d = ST_REPORT;
          fail_d  = 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    phy_request_d = (state_d == ST_SOP_WAIT) || (state_d == ST_HR_WAIT);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      type_q        <= 3'd0;
      retry_q       <= 2'd0;
      attempts_q    <= 3'd0;
      phy_request_q <= 1'b0;
      phy_abort_q   <= 1'b0;
      succ_q        <= 1'b0;
      fail_q        <= 1'b0;
      disc_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      retry_q       <= retry_d;
      attempts_q    <= attempts_d;
      phy_request_q <= phy_request_d;
      phy_abort_q   <= phy_abort_d;
      succ_q        <= succ_d;
      fail_q        <= fail_d;
      disc_q        <= disc_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.phy_request                       = phy_request_q;
  assign bus.phy_sop_type                      = type_q;
  assign bus.phy_abort                         = phy_abort_q;
  assign bus.ALERT_TransmitSuccessful          = succ_q;
  assign bus.ALERT_TransmitSOPMessageFailed    = fail_q;
  assign bus.ALERT_TransmitSOPMessageDiscarded = disc_q;
  assign bus.busy                              = busy_q;

endmodule

// File: tb/tb_tcpc_transmit_arbiter.sv
// Directed and randomized bench for tcpc_transmit_arbiter against a
// cycle-level behavioural model of the transmit scheduling rules.
module tb_tcpc_transmit_arbiter;

  localparam int TX_LIM  = 20;
  localparam int RST_LIM = 50;

  localparam int M_IDLE = 0, M_SOP = 1, M_GAP = 2, M_ABORT = 3, M_HR = 4, M_REPORT = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  tcpc_transmit_arbiter_if bus ();

  tcpc_transmit_arbiter #(
    .TIMER_W         (32),
    .MAX_RESET_TIMER (RST_LIM),
    .MAX_TX_TIMER    (TX_LIM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode, cycles spent in the current wait, retries still allowed.
  int         m_mode;
  int         m_age;
  int         m_left;
  logic [2:0] m_type;
  logic       e_req, e_abort, e_succ, e_fail, e_disc, e_busy;

  task automatic model_reset();
    m_mode = M_IDLE; m_age = 0; m_left = 0; m_type = 3'd0;
    e_req = 0; e_abort = 0; e_succ = 0; e_fail = 0; e_disc = 0; e_busy = 0;
  endtask

  task automatic model_step(input bit req, input logic [7:0] tx, input bit rxb,
                            input bit done, input bit fl);
    int  t;
    bit  is_rst, timed_out;
    t = int'(tx[2:0]);
    is_rst = (t == 5) || (t == 6);
    e_succ = 0; e_fail = 0; e_disc = 0; e_abort = 0;
    if (req && !is_rst && m_mode != M_IDLE) e_disc = 1;
    timed_out = 0;
    if (m_mode == M_SOP) begin timed_out = (m_age >= TX_LIM);  m_age++; end
    if (m_mode == M_HR)  begin timed_out = (m_age >= RST_LIM); m_age++; end
    case (m_mode)
      M_IDLE: if (req) begin
        if (is_rst) begin m_type = tx[2:0]; m_mode = M_HR; m_age = 0; end
        else if (t == 7) begin m_mode = M_REPORT; e_fail = 1; end
        else if (rxb) begin m_mode = M_REPORT; e_disc = 1; end
        else begin m_type = tx[2:0]; m_left = int'(tx[5:4]); m_mode = M_SOP; m_age = 0; end
      end
      M_SOP, M_GAP: begin
        if (req && is_rst) begin
          m_type = tx[2:0]; m_mode = M_ABORT; e_abort = 1; e_disc = 1;
        end else if (m_mode == M_GAP) begin
          m_mode = M_SOP; m_age = 0;
        end else if (done) begin
          m_mode = M_REPORT; e_succ = 1;
        end else if (fl || timed_out) begin
          if (m_left == 0) begin m_mode = M_REPORT; e_fail = 1; end
          else begin m_left--; m_mode = M_GAP; end
        end
      end
      M_ABORT: begin m_mode = M_HR; m_age = 0; end
      M_HR: begin
        if (done) begin m_mode = M_REPORT; e_succ = 1; end
        else if (timed_out) begin m_mode = M_REPORT; e_fail = 1; end
      end
      default: m_mode = M_IDLE;
    endcase
    e_req  = (m_mode == M_SOP) || (m_mode == M_HR);
    e_busy = (m_mode != M_IDLE);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("phy_request", 8'(bus.phy_request), 8'(e_req));
    chk("phy_abort",   8'(bus.phy_abort),   8'(e_abort));
    chk("alert_succ",  8'(bus.ALERT_TransmitSuccessful),          8'(e_succ));
    chk("alert_fail",  8'(bus.ALERT_TransmitSOPMessageFailed),    8'(e_fail));
    chk("alert_disc",  8'(bus.ALERT_TransmitSOPMessageDiscarded), 8'(e_disc));
    chk("busy",        8'(bus.busy),        8'(e_busy));
    if (e_req) chk("phy_sop_type", 8'(bus.phy_sop_type), 8'(m_type));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   8'(bus.phy_request), 8'd0);
    chk({tag, "_type"},  8'(bus.phy_sop_type), 8'd0);
    chk({tag, "_abort"}, 8'(bus.phy_abort), 8'd0);
    chk({tag, "_succ"},  8'(bus.ALERT_TransmitSuccessful), 8'd0);
    chk({tag, "_fail"},  8'(bus.ALERT_TransmitSOPMessageFailed), 8'd0);
    chk({tag, "_disc"},  8'(bus.ALERT_TransmitSOPMessageDiscarded), 8'd0);
    chk({tag, "_busy"},  8'(bus.busy), 8'd0);
  endtask

  task automatic tick(input bit req, input logic [7:0] tx, input bit rxb,
                      input bit done, input bit fl);
    bus.transmit_req = req;
    bus.TRANSMIT     = tx;
    bus.rx_busy      = rxb;
    bus.phy_done     = done;
    bus.phy_fail     = fl;
    @(posedge clk);
    model_step(req, tx, rxb, done, fl);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.transmit_req = 0; bus.TRANSMIT = 8'h00; bus.rx_busy = 0;
    bus.phy_done = 0; bus.phy_fail = 0;
    model_reset();

    // Power-on reset
    #1 reset = 1'b1;
    #1 check_all_zero("por");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    model_reset();
    idle(2);

    // SOP success: retry 3, GoodCRC 5 cycles after the request
    tick(1, 8'h30, 0, 0, 0);
    idle(4);
    tick(0, 8'h00, 0, 1, 0);
    idle(3);

    // Retry exhaustion: retry 1, both attempts fail
    tick(1, 8'h10, 0, 0, 0);
    idle(3);
    tick(0, 8'h00, 0, 0, 1);
    idle(3);
    tick(0, 8'h00, 0, 0, 1);
    idle(3);

    // Response timeout with silent PHY
    tick(1, 8'h02, 0, 0, 0);
    idle(26);

    // Pre-emption of an SOP by Hard Reset, then reset signalling completes
    tick(1, 8'h01, 0, 0, 0);
    idle(3);
    tick(1, 8'h05, 0, 0, 0);
    idle(4);
    tick(0, 8'h00, 0, 1, 0);
    idle(2);

    // Cable Reset timeout, requested while receiving; phy_fail ignored
    tick(1, 8'h06, 1, 0, 0);
    tick(0, 8'h00, 1, 0, 1);
    idle(RST_LIM + 3);

    // Collision discard, reserved type, and message request while busy
    tick(1, 8'h03, 1, 0, 0);
    idle(2);
    tick(1, 8'h07, 0, 0, 0);
    idle(2);
    tick(1, 8'h00, 0, 0, 0);
    tick(1, 8'h04, 0, 0, 0);
    tick(0, 8'h00, 0, 1, 1);
    tick(1, 8'h02, 0, 0, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit         r, d, f, b;
      logic [7:0] tx;
      r  = ($urandom_range(0, 7) == 0);
      d  = ($urandom_range(0, 9) == 0);
      f  = ($urandom_range(0, 7) == 0);
      b  = ($urandom_range(0, 3) == 0);
      tx = 8'($urandom);
      tick(r, tx, b, d, f);
    end
    idle(RST_LIM + 5);

    // Asynchronous reset in the middle of Hard Reset signalling
    tick(1, 8'h05, 0, 0, 0);
    idle(5);
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    model_reset();
    idle(RST_LIM + 5);
    tick(1, 8'h20, 0, 0, 0);
    idle(2);
    tick(0, 8'h00, 0, 1, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
